fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction-fetch stage and IF/ID pipeline register of the RISC-V core. It is the consumer end of the decode control interface: it takes pcSel, pcStall and ifidStall from the control unit and delivers dinst and dpc back to it. Toward instruction memory it owns the PC and drives a single-outstanding request/grant/response handshake. It also handles redirects, squashes of in-flight fetches, and stall buffering.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
TRAP_VEC, 32'h0000_0004, target address for pcSel=3
NOP, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
pcSel  in  2  next-PC select: 0 pc+4, 1 brTarget, 2 jalrTarget, 3 TRAP_VEC
pcStall  in  1  hold PC; pcSel is ignored while set
ifidStall  in  1  hold IF/ID contents
brTarget  in  32  branch/JAL target
jalrTarget  in  32  JALR target; bit0 is ignored
imemReq  out  1  fetch request
imemAddr  out  32  fetch address, word aligned
imemGnt  in  1  request accepted this cycle
imemRvalid  in  1  response data valid
imemRdata  in  32  response instruction
dinst  out  32  IF/ID instruction to decode
dpc  out  32  PC of dinst
dvalid  out  1  dinst is a real fetched instruction (0 = bubble)

Behaviour:
- Reset, asynchronous, while resetn=0:
  - pc=RESET_PC; state=REQ; squash=0.
  - dinst=NOP; dpc=0; dvalid=0.
  - imemReq=0 (forced combinationally low).
- redirect = (pcSel!=0) && !pcStall.
- tgt: pcSel=1 gives brTarget. pcSel=2 gives jalrTarget with [0] cleared. pcSel=3 gives TRAP_VEC. Bits [1:0] of every target are then forced to 0.
- At most one request is outstanding. The memory returns imemRvalid at least 1 cycle after the granting cycle, in order.
- States: REQ (no request outstanding), WAIT (granted, awaiting response), HOLD (response captured in skid buffer, IF/ID stalled).
- REQ:
  - imemReq=1; imemAddr = redirect ? tgt : pc.
  - On redirect: pc<=tgt.
  - If imemGnt: go to WAIT; reqPc<=imemAddr.
  - IF/ID update (only when !ifidStall or redirect): dinst<=NOP, dvalid<=0.
- WAIT, no imemRvalid:
  - imemReq=0.
  - On redirect: pc<=tgt, squash<=1, IF/ID<=NOP.
  - Otherwise, if !ifidStall: IF/ID<=NOP bubble.
- WAIT, imemRvalid with (squash || redirect):
  - Drop data; squash<=0; IF/ID<=NOP.
  - If redirect: pc<=tgt.
  - Issue the next request combinationally in the same cycle: imemReq=1, addr = redirect ? tgt : pc. If granted go to WAIT, else go to REQ.
- WAIT, imemRvalid, clean, !ifidStall:
  - dinst<=imemRdata; dpc<=reqPc; dvalid<=1; pc<=reqPc+4.
  - Back-to-back: imemReq=1, addr=reqPc+4 the same cycle. Gnt goes to WAIT, else REQ.
  - Sustains 1 instruction/cycle with 1-cycle memory.
- WAIT, imemRvalid, clean, ifidStall:
  - skid<=imemRdata; go to HOLD; IF/ID holds.
- HOLD:
  - imemReq=0.
  - On redirect: drop skid; pc<=tgt; IF/ID<=NOP; go to REQ.
  - Else if !ifidStall: IF/ID<=(skid, reqPc, 1); pc<=reqPc+4; go to REQ.
- Priorities and stalls:
  - Redirect flush of IF/ID overrides ifidStall.
  - pcStall only freezes pc and masks pcSel. It never drops a returning response.
- PC arithmetic is 32-bit and wraps modulo 2^32 (0xFFFF_FFFC+4 = 0).
- Reset asserted mid-operation abandons any outstanding request. Responses arriving after reset release while in REQ are ignored.

Test Plan:
- Sequential fetch: reset, release. Memory grants immediately with 1-cycle latency, word at addr A = A|0x13 -> imemAddr 0,4,8,12 on consecutive cycles. dinst/dpc = (0x13,0), (0x17,4), (0x1B,8). dvalid=1 from cycle 2 onward.
- Stall buffering: ifidStall=1 for 3 cycles when the response for 0x8 arrives -> state HOLD, imemReq=0, dinst unchanged. On release, dinst=word@0x8, dpc=8, and the next request is to 0xC.
- Branch squash: brTarget=0x100, pcSel=1 for one cycle while the 0x10 fetch is outstanding with 3-cycle latency -> the 0x10 response is dropped, dvalid=0 for the bubble, next request is 0x100, next valid dpc=0x100.
- JALR alignment: pcSel=2, jalrTarget=0x203 in REQ -> imemAddr=0x200 in the same cycle, pc=0x200.
- pcStall masking: pcStall=1, pcSel=1, brTarget=0x400 -> no redirect, pc unchanged, in-flight data delivered normally.
- Reset mid-WAIT: resetn low for 1 cycle while awaiting the response -> dinst=NOP, dvalid=0, imemReq=0 during reset. Late rvalid is ignored; the first request after release is RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage plus IF/ID pipeline register.
//
// Owns the PC and drives a single-outstanding request/grant/response
// handshake to instruction memory. Handles redirects from the control unit,
// squashes a fetch that was already in flight when a redirect happened, and
// parks a returning instruction in a skid register while IF/ID is stalled.
//
// Ports:
//   clk, resetn              clock (rising edge), async active-low reset
//   pcSel[1:0]               next-PC select: 0 pc+4, 1 brTarget, 2 jalrTarget, 3 TRAP_VEC
//   pcStall                  masks pcSel (no redirect while set)
//   ifidStall                hold IF/ID contents
//   brTarget, jalrTarget     redirect targets
//   imemReq, imemAddr        fetch request and word-aligned address
//   imemGnt                  request accepted this cycle
//   imemRvalid, imemRdata    in-order response
//   dinst, dpc, dvalid       IF/ID register toward decode
//
// state | meaning
// ------+--------------------------------------------------------------
// REQ   | no request outstanding, requesting pc (or redirect target)
// WAIT  | request granted, awaiting its response
// HOLD  | response parked in skid register while IF/ID is stalled

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0004,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  pcSel,
    input  logic        pcStall,
    input  logic        ifidStall,
    input  logic [31:0] brTarget,
    input  logic [31:0] jalrTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic [31:0] dinst,
    output logic [31:0] dpc,
    output logic        dvalid
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] skid_q, skid_d;
    logic        squash_q, squash_d;
    logic [31:0] dinst_q, dinst_d;
    logic [31:0] dpc_q, dpc_d;
    logic        dvalid_q, dvalid_d;

    logic        redirect;
    logic [31:0] tgt_raw;
    logic [31:0] tgt;
    logic [31:0] seq_pc;
    logic        req_c;
    logic [31:0] addr_c;

    assign redirect = (pcSel != 2'd0) && !pcStall;
    assign seq_pc   = req_pc_q + 32'd4;

    // Clearing [1:0] of every target also covers the JALR bit0 rule.
    always_comb begin
        tgt_raw = '0;
        case (pcSel)
            2'd1:    tgt_raw = brTarget;
            2'd2:    tgt_raw = jalrTarget;
            2'd3:    tgt_raw = TRAP_VEC;
            default: tgt_raw = '0;
        endcase
        tgt = tgt_raw & 32'hFFFF_FFFC;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        skid_d   = skid_q;
        squash_d = squash_q;
        dinst_d  = dinst_q;
        dpc_d    = dpc_q;
        dvalid_d = dvalid_q;
        req_c    = 1'b0;
        addr_c   = pc_q;

        case (state_q)
            S_REQ: begin
                req_c  = 1'b1;
                addr_c = redirect ? tgt : pc_q;
                if (redirect) pc_d = tgt;
                if (imemGnt) begin
                    state_d  = S_WAIT;
                    req_pc_d = addr_c;
                end
                if (!ifidStall || redirect) begin
                    dinst_d  = NOP;
                    dvalid_d = 1'b0;
                end
            end

            S_WAIT: begin
                if (!imemRvalid) begin
                    if (redirect) begin
                        pc_d     = tgt;
                        squash_d = 1'b1;
                        dinst_d  = NOP;
                        dvalid_d = 1'b0;
                    end else if (!ifidStall) begin
                        dinst_d  = NOP;
                        dvalid_d = 1'b0;
                    end
                end else if (squash_q || redirect) begin
                    // Stale response: drop it and immediately fetch the new path.
                    squash_d = 1'b0;
                    if (!ifidStall || redirect) begin
                        dinst_d  = NOP;
                        dvalid_d = 1'b0;
                    end
                    if (redirect) pc_d = tgt;
                    req_c  = 1'b1;
                    addr_c = redirect ? tgt : pc_q;
                    if (imemGnt) req_pc_d = addr_c;
                    else         state_d  = S_REQ;
                end else if (!ifidStall) begin
                    dinst_d  = imemRdata;
                    dpc_d    = req_pc_q;
                    dvalid_d = 1'b1;
                    pc_d     = seq_pc;
                    // Back-to-back request keeps one instruction per cycle.
                    req_c    = 1'b1;
                    addr_c   = seq_pc;
                    if (imemGnt) req_pc_d = seq_pc;
                    else         state_d  = S_REQ;
                end else begin
                    skid_d  = imemRdata;
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    pc_d     = tgt;
                    dinst_d  = NOP;
                    dvalid_d = 1'b0;
                    state_d  = S_REQ;
                end else if (!ifidStall) begin
                    dinst_d  = skid_q;
                    dpc_d    = req_pc_q;
                    dvalid_d = 1'b1;
                    pc_d     = seq_pc;
                    state_d  = S_REQ;
                end
            end

            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            skid_q   <= NOP;
            squash_q <= 1'b0;
            dinst_q  <= NOP;
            dpc_q    <= '0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            skid_q   <= skid_d;
            squash_q <= squash_d;
            dinst_q  <= dinst_d;
            dpc_q    <= dpc_d;
            dvalid_q <= dvalid_d;
        end
    end

    // Request is gated by reset so nothing is issued while resetn is low.
    assign imemReq  = req_c & resetn;
    assign imemAddr = addr_c;
    assign dinst    = dinst_q;
    assign dpc      = dpc_q;
    assign dvalid   = dvalid_q;

endmodule
